addac_4: RTL and testbench

4-bit adder/accumulator datapath block: a ripple-carry adder/subtractor feeding a 4-bit accumulator register with a registered carry flag. Each clock the accumulator either adds the input operand, adds the operand's complement, loads the operand, or clears. Used as the arithmetic slice of the small ALU/accumulator datapath. Results are visible on `s` and `cout` one clock after the operation is presented.

---
 rtl/addac_pkg.sv | 18 +
 rtl/full_adder.sv | 15 +
 rtl/addac_4.sv | 74 +++++++
 tb/tb_addac_4.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/addac_pkg.sv
// Shared definitions for the 4-bit adder/accumulator slice.
package addac_pkg;

   localparam int unsigned WIDTH = 4;

   // Operation encoding, keyed by {sel1, sel0}.
   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_LOAD = 2'b10,
      OP_CLR  = 2'b11
   } addac_op_e;

   function automatic addac_op_e decode_op(input logic sel1, input logic sel0);
      return addac_op_e'({sel1, sel0});
   endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder, one stage of the accumulator's ripple-carry chain.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   always_comb begin
      s  = a ^ b ^ ci;
      co = (a & b) | (ci & (a ^ b));
   end

endmodule

// File: rtl/addac_4.sv
// 4-bit accumulator: ripple adder/subtractor feeding an accumulator register with
// a registered carry flag. Outputs are direct register outputs, one-clock latency.
module addac_4
   import addac_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic             sel0,
   input  logic             sel1,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic             cf_q, cf_d;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] sum;
   logic [WIDTH:0]   carry;
   addac_op_e        op;

   assign op       = decode_op(sel1, sel0);
   assign b        = sel0 ? ~a : a;
   assign carry[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
      full_adder u_fa (
         .a  (acc_q[i]),
         .b  (b[i]),
         .ci (carry[i]),
         .s  (sum[i]),
         .co (carry[i+1])
      );
   end

   always_comb begin
      acc_d = acc_q;
      cf_d  = cf_q;
      unique case (op)
         OP_ADD, OP_SUB: begin
            acc_d = sum;
            cf_d  = carry[WIDTH];
         end
         OP_LOAD: begin
            acc_d = a;
            cf_d  = 1'b0;
         end
         OP_CLR: begin
            acc_d = '0;
            cf_d  = 1'b0;
         end
         default: begin
            acc_d = '0;
            cf_d  = 1'b0;
         end
      endcase
   end

   // Synchronous active-low reset overrides any selected operation.
   always_ff @(posedge clk) begin
      if (!rst) begin
         acc_q <= '0;
         cf_q  <= 1'b0;
      end else begin
         acc_q <= acc_d;
         cf_q  <= cf_d;
      end
   end

   assign s    = acc_q;
   assign cout = cf_q;

endmodule

// File: tb/tb_addac_4.sv
// Directed and randomized checks of addac_4 with a queue-based scoreboard.
module tb_addac_4;

   logic       clk;
   logic       rst;
   logic [3:0] a;
   logic       sel0;
   logic       sel1;
   logic       cin;
   logic [3:0] s;
   logic       cout;

   int checks = 0;
   int errors = 0;

   logic [4:0] exp_q[$];
   string      tag_q[$];

   // Reference state of the accumulator, tracked independently of the DUT.
   logic [3:0] m_acc;
   logic       m_cf;

   addac_4 dut (
      .clk  (clk),
      .rst  (rst),
      .a    (a),
      .sel0 (sel0),
      .sel1 (sel1),
      .cin  (cin),
      .s    (s),
      .cout (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_step(input logic r, input logic s1, input logic s0,
                             input logic [3:0] av, input logic ci);
      logic [4:0] t;
      if (!r) begin
         m_acc = 4'h0;
         m_cf  = 1'b0;
      end else begin
         case ({s1, s0})
            2'b00: begin t = {1'b0, m_acc} + {1'b0, av} + {4'b0, ci};
                         m_acc = t[3:0]; m_cf = t[4]; end
            2'b01: begin t = {1'b0, m_acc} + {1'b0, ~av} + {4'b0, ci};
                         m_acc = t[3:0]; m_cf = t[4]; end
            2'b10: begin m_acc = av;   m_cf = 1'b0; end
            default: begin m_acc = 4'h0; m_cf = 1'b0; end
         endcase
      end
   endtask

   // Drive one operation, push its expected result, then compare after the edge.
   task automatic step(input string tag, input logic r, input logic s1, input logic s0,
                       input logic [3:0] av, input logic ci, input logic [4:0] expv);
      logic [4:0] e;
      string      t;
      @(negedge clk);
      rst  = r;
      sel1 = s1;
      sel0 = s0;
      a    = av;
      cin  = ci;
      exp_q.push_back(expv);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      assert ({cout, s} === e)
      else begin
         errors++;
         $error("FAIL %s: observed cout=%b s=%b expected cout=%b s=%b",
                t, cout, s, e[4], e[3:0]);
      end
   endtask

   // Randomized step: expectation comes from the reference model.
   task automatic rand_step(input int n);
      logic       s1, s0, ci;
      logic [3:0] av;
      s1 = 1'($urandom_range(0, 1));
      s0 = 1'($urandom_range(0, 1));
      ci = s0;
      if ($urandom_range(0, 3) == 0) ci = ~ci;
      av = 4'($urandom_range(0, 15));
      model_step(1'b1, s1, s0, av, ci);
      step($sformatf("rand%0d", n), 1'b1, s1, s0, av, ci, {m_cf, m_acc});
   endtask

   initial begin
      rst = 1'b0; a = 4'hF; sel0 = 1'b0; sel1 = 1'b0; cin = 1'b0;

      step("reset0", 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 5'b0_0000);
      step("reset1", 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 5'b0_0000);

      step("add1",   1'b1, 1'b0, 1'b0, 4'b0011, 1'b0, 5'b0_0011);
      step("add2",   1'b1, 1'b0, 1'b0, 4'b0011, 1'b0, 5'b0_0110);
      step("add3",   1'b1, 1'b0, 1'b0, 4'b0011, 1'b0, 5'b0_1001);
      step("add_ovf", 1'b1, 1'b0, 1'b0, 4'b1000, 1'b0, 5'b1_0001);

      step("load7",  1'b1, 1'b1, 1'b0, 4'b0111, 1'b0, 5'b0_0111);
      step("sub2",   1'b1, 1'b0, 1'b1, 4'b0010, 1'b1, 5'b1_0101);
      step("sub6",   1'b1, 1'b0, 1'b1, 4'b0110, 1'b1, 5'b0_1111);

      step("load_ci1", 1'b1, 1'b1, 1'b0, 4'b1010, 1'b1, 5'b0_1010);
      step("clr_ci1",  1'b1, 1'b1, 1'b1, 4'b0101, 1'b1, 5'b0_0000);
      step("load_ci0", 1'b1, 1'b1, 1'b0, 4'b1010, 1'b0, 5'b0_1010);
      step("clr_ci0",  1'b1, 1'b1, 1'b1, 4'b0101, 1'b0, 5'b0_0000);

      step("loadF",   1'b1, 1'b1, 1'b0, 4'b1111, 1'b0, 5'b0_1111);
      step("wrap",    1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 5'b1_0000);
      step("add_cin", 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 5'b0_0001);

      step("clr",     1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 5'b0_0000);
      step("acc1",    1'b1, 1'b0, 1'b0, 4'b0011, 1'b0, 5'b0_0011);
      step("acc2",    1'b1, 1'b0, 1'b0, 4'b0011, 1'b0, 5'b0_0110);
      step("acc3",    1'b1, 1'b0, 1'b0, 4'b0011, 1'b0, 5'b0_1001);
      step("mid_rst", 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 5'b0_0000);
      step("resume",  1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 5'b0_0001);

      step("rand_clr", 1'b1, 1'b1, 1'b1, 4'b1001, 1'b1, 5'b0_0000);
      m_acc = 4'h0;
      m_cf  = 1'b0;
      for (int i = 0; i < 60; i++) rand_step(i);

      checks++;
      assert (exp_q.size() == 0)
      else begin
         errors++;
         $error("FAIL scoreboard_drain: observed %0d pending expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no completion expected finish before 100000");
      $fatal(1, "timeout");
   end

endmodule
